// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator.
// The master drives coordinates, strobes and VGA pins; the slave returns rgb_in.
interface vga_timing_gen_if;
   logic [23:0] rgb_in;
   logic        pix_en;
   logic [9:0]  x;
   logic [8:0]  y;
   logic        active;
   logic        line_start;
   logic        frame_start;
   logic [7:0]  VGA_R;
   logic [7:0]  VGA_G;
   logic [7:0]  VGA_B;
   logic        VGA_HS;
   logic        VGA_VS;
   logic        VGA_BLANK_N;

   modport master (
      input  rgb_in,
      output pix_en, x, y, active, line_start, frame_start,
      output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
   );

   modport slave (
      output rgb_in,
      input  pix_en, x, y, active, line_start, frame_start,
      input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA pixel timing and output stage.
// Divides CLOCK_50 to a pixel enable, runs the h/v counters, and delays sync/blank so
// they line up with the colour returned by the pixel logic.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0,
   parameter int unsigned PIPE_LAT = 1
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   vga_timing_gen_if.master  io_vga
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } ctl_t;

   logic [DIV_W-1:0] r_div_cnt;
   logic [9:0]       r_h_count;
   logic [9:0]       r_v_count;
   logic [23:0]      r_rgb;
   ctl_t             r_pipe [PIPE_LAT];

   logic w_pix_en;
   ctl_t w_ctl;
   logic w_prev_act;

   // Gated by reset so no strobe escapes while reset is held.
   assign w_pix_en = ~reset && (r_div_cnt == DIV_LAST);

   // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_div_cnt <= '0;
      end else if (r_div_cnt == DIV_LAST) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   // Horizontal/vertical position counters, stepping once per pixel period.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_h_count <= '0;
         r_v_count <= '0;
      end else if (w_pix_en) begin
         if (r_h_count == H_LAST) begin
            r_h_count <= '0;
            r_v_count <= (r_v_count == V_LAST) ? '0 : r_v_count + 10'd1;
         end else begin
            r_h_count <= r_h_count + 10'd1;
         end
      end
   end

   // Decode of the pixel currently being issued.
   always_comb begin
      w_ctl     = '0;
      w_ctl.act = (r_h_count < H_ACT) && (r_v_count < V_ACT);
      w_ctl.hs  = (r_h_count >= HS_FIRST) && (r_h_count <= HS_LAST);
      w_ctl.vs  = (r_v_count >= VS_FIRST) && (r_v_count <= VS_LAST);
   end

   // The colour arriving now belongs to the pixel issued PIPE_LAT-1 periods ago.
   generate
      if (PIPE_LAT == 1) begin : g_lat_one
         assign w_prev_act = w_ctl.act;
      end else begin : g_lat_many
         assign w_prev_act = r_pipe[PIPE_LAT-2].act;
      end
   endgenerate

   // Control delay line and colour register; reset fills with idle (no sync, blanked).
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < int'(PIPE_LAT); i++) begin
            r_pipe[i] <= '0;
         end
         r_rgb <= '0;
      end else if (w_pix_en) begin
         r_pipe[0] <= w_ctl;
         for (int i = 1; i < int'(PIPE_LAT); i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
         r_rgb <= w_prev_act ? io_vga.rgb_in : 24'h0;
      end
   end

   assign io_vga.pix_en      = w_pix_en;
   assign io_vga.x           = r_h_count;
   assign io_vga.y           = r_v_count[8:0];
   assign io_vga.active      = w_ctl.act;
   assign io_vga.line_start  = w_pix_en && (r_h_count == 10'd0);
   assign io_vga.frame_start = w_pix_en && (r_h_count == 10'd0) && (r_v_count == 10'd0);

   assign io_vga.VGA_R       = r_rgb[23:16];
   assign io_vga.VGA_G       = r_rgb[15:8];
   assign io_vga.VGA_B       = r_rgb[7:0];
   assign io_vga.VGA_HS      = r_pipe[PIPE_LAT-1].hs ? SYNC_POL : ~SYNC_POL;
   assign io_vga.VGA_VS      = r_pipe[PIPE_LAT-1].vs ? SYNC_POL : ~SYNC_POL;
   assign io_vga.VGA_BLANK_N = r_pipe[PIPE_LAT-1].act;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size default instance, a shrunken-frame
// instance for vertical timing, and a CLK_DIV=1 / PIPE_LAT=3 instance.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst0;
   logic rst_c;
   logic sel_white;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   // Cycle counter stepped on the active edge; read only at negedge.
   always @(posedge clk) cyc <= cyc + 1;

   vga_timing_gen_if if0 ();
   vga_timing_gen_if if1 ();
   vga_timing_gen_if if2 ();

   vga_timing_gen u_dut0 (
      .CLOCK_50 (clk),
      .reset    (rst0),
      .io_vga   (if0)
   );

   vga_timing_gen #(
      .CLK_DIV  (2),
      .H_ACTIVE (16),
      .H_FP     (2),
      .H_SYNC   (4),
      .H_BP     (2),
      .V_ACTIVE (10),
      .V_FP     (2),
      .V_SYNC   (2),
      .V_BP     (3)
   ) u_dut1 (
      .CLOCK_50 (clk),
      .reset    (rst_c),
      .io_vga   (if1)
   );

   vga_timing_gen #(
      .CLK_DIV  (1),
      .PIPE_LAT (3)
   ) u_dut2 (
      .CLOCK_50 (clk),
      .reset    (rst_c),
      .io_vga   (if2)
   );

   assign if0.rgb_in = sel_white ? 24'hFFFFFF : {if0.x[7:0], if0.y[7:0], 8'hA5};
   assign if1.rgb_in = 24'h123456;

   // Pixel logic for dut2 modelled as a two-stage pipeline, so its rgb_in belongs
   // to the pixel issued two periods earlier.
   logic [9:0] d1_x, d2_x;
   logic [8:0] d1_y, d2_y;
   always @(posedge clk) begin
      if (if2.pix_en) begin
         d1_x <= if2.x;
         d1_y <= if2.y;
         d2_x <= d1_x;
         d2_y <= d1_y;
      end
   end
   assign if2.rgb_in = {d2_x[7:0], d2_y[7:0], 8'hA5};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef enum int {WHs0Lo, WHs0Hi, WLs0, WXy0, WXy1, WXy2, WFs1, WVs1Lo, WVs1Hi,
                     WLs2} wait_e;

   function automatic bit probe(input wait_e k, input int xv, input int yv);
      case (k)
         WHs0Lo: return if0.VGA_HS == 1'b0;
         WHs0Hi: return if0.VGA_HS == 1'b1;
         WLs0:   return if0.line_start == 1'b1;
         WXy0:   return (if0.x == 10'(xv)) && (if0.y == 9'(yv));
         WXy1:   return (if1.x == 10'(xv)) && (if1.y == 9'(yv));
         WXy2:   return (if2.x == 10'(xv)) && (if2.y == 9'(yv));
         WFs1:   return if1.frame_start == 1'b1;
         WVs1Lo: return if1.VGA_VS == 1'b0;
         WVs1Hi: return if1.VGA_VS == 1'b1;
         WLs2:   return if2.line_start == 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Poll at negedge until the probe holds, with a bounded budget.
   task automatic wait_for(input wait_e k, input int xv, input int yv, input string tag);
      int n = 0;
      while (!probe(k, xv, yv) && n < 60000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60000) check({tag, " timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int t0, t1, t2, cnt;
      rst0      = 1'b1;
      rst_c     = 1'b1;
      sel_white = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);

      // Reset state of the default instance.
      check("rst_hs", 32'(if0.VGA_HS), 32'd1);
      check("rst_vs", 32'(if0.VGA_VS), 32'd1);
      check("rst_blank_n", 32'(if0.VGA_BLANK_N), 32'd0);
      check("rst_rgb", 32'({if0.VGA_R, if0.VGA_G, if0.VGA_B}), 32'd0);
      check("rst_xy", 32'({if0.x, if0.y}), 32'd0);
      check("rst_pix_en", 32'(if0.pix_en), 32'd0);

      // Release: pix_en on the 2nd cycle and every other one after.
      rst0  = 1'b0;
      rst_c = 1'b0;
      #1;
      check("lat3_pix_en_first", 32'(if2.pix_en), 32'd1);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("pix_en_c%0d", i + 1), 32'(if0.pix_en), 32'(i % 2));
         if (i == 1) check("frame_start_first", 32'(if0.frame_start), 32'd1);
         @(negedge clk);
      end

      // Horizontal sync placement and width.
      wait_for(WXy0, 656, 0, "x656");
      t0 = cyc;
      wait_for(WHs0Lo, 0, 0, "hs_fall1");
      t1 = cyc;
      check("hs_fall_delay", 32'(t1 - t0), 32'd2);
      wait_for(WHs0Hi, 0, 0, "hs_rise1");
      check("hs_low_width", 32'(cyc - t1), 32'd192);
      wait_for(WHs0Lo, 0, 0, "hs_fall2");
      check("hs_period", 32'(cyc - t1), 32'd1600);

      wait_for(WLs0, 0, 0, "ls1");
      t0 = cyc;
      @(negedge clk);
      wait_for(WLs0, 0, 0, "ls2");
      check("line_start_period", 32'(cyc - t0), 32'd1600);

      // Colour alignment at pixel (3,7): visible once x has moved on to 4.
      wait_for(WXy0, 4, 7, "px_3_7");
      check("px37_r", 32'(if0.VGA_R), 32'h03);
      check("px37_g", 32'(if0.VGA_G), 32'h07);
      check("px37_b", 32'(if0.VGA_B), 32'hA5);
      check("px37_blank_n", 32'(if0.VGA_BLANK_N), 32'd1);

      // Blanked pixels stay black with white input.
      wait_for(WXy0, 0, 8, "white_start");
      sel_white = 1'b1;
      wait_for(WXy0, 100, 8, "white_100");
      check("white_vis_r", 32'(if0.VGA_R), 32'hFF);
      wait_for(WXy0, 640, 8, "white_640");
      check("white_639_rgb", 32'({if0.VGA_R, if0.VGA_G, if0.VGA_B}), 32'hFFFFFF);
      wait_for(WXy0, 641, 8, "white_641");
      check("white_640_rgb", 32'({if0.VGA_R, if0.VGA_G, if0.VGA_B}), 32'd0);
      check("white_640_blank_n", 32'(if0.VGA_BLANK_N), 32'd0);
      wait_for(WXy0, 700, 8, "white_700");
      check("white_699_rgb", 32'({if0.VGA_R, if0.VGA_G, if0.VGA_B}), 32'd0);
      wait_for(WXy0, 0, 9, "white_end");
      sel_white = 1'b0;

      // Mid-frame reset for one cycle.
      wait_for(WXy0, 300, 9, "mid_rst_point");
      rst0 = 1'b1;
      @(negedge clk);
      check("mid_rst_pix_en", 32'(if0.pix_en), 32'd0);
      check("mid_rst_xy", 32'({if0.x, if0.y}), 32'd0);
      check("mid_rst_hs", 32'(if0.VGA_HS), 32'd1);
      check("mid_rst_blank_n", 32'(if0.VGA_BLANK_N), 32'd0);
      rst0 = 1'b0;
      #1;
      check("mid_rel_pix_en_c1", 32'(if0.pix_en), 32'd0);
      @(negedge clk);
      check("mid_rel_pix_en_c2", 32'(if0.pix_en), 32'd1);
      check("mid_rel_frame_start", 32'(if0.frame_start), 32'd1);
      check("mid_rel_xy", 32'({if0.x, if0.y}), 32'd0);

      // Shrunken frame: 24 x 17 pixels at CLK_DIV=2 is 816 cycles per frame.
      wait_for(WFs1, 0, 0, "fs1");
      t0 = cyc;
      @(negedge clk);
      wait_for(WFs1, 0, 0, "fs2");
      check("frame_period", 32'(cyc - t0), 32'd816);
      cnt = 0;
      for (int i = 0; i < 816; i++) begin
         if (if1.pix_en && if1.VGA_BLANK_N) cnt++;
         @(negedge clk);
      end
      check("blank_n_per_frame", 32'(cnt), 32'd160);
      wait_for(WVs1Lo, 0, 0, "vs_fall");
      t2 = cyc;
      check("vs_fall_xy", 32'({if1.x, if1.y}), 32'({10'd1, 9'd12}));
      wait_for(WVs1Hi, 0, 0, "vs_rise");
      check("vs_low_width", 32'(cyc - t2), 32'd96);
      wait_for(WXy1, 5, 3, "v_line3");
      check("blank_n_line3", 32'(if1.VGA_BLANK_N), 32'd1);
      wait_for(WXy1, 5, 13, "v_line13");
      check("blank_n_line13", 32'(if1.VGA_BLANK_N), 32'd0);

      // CLK_DIV=1, PIPE_LAT=3.
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (if2.pix_en) cnt++;
         @(negedge clk);
      end
      check("lat3_pix_en_const", 32'(cnt), 32'd20);
      wait_for(WLs2, 0, 0, "lat3_ls1");
      t0 = cyc;
      @(negedge clk);
      wait_for(WLs2, 0, 0, "lat3_ls2");
      check("lat3_line_period", 32'(cyc - t0), 32'd800);
      wait_for(WXy2, 3, 40, "lat3_x3");
      check("lat3_px0_blank_n", 32'(if2.VGA_BLANK_N), 32'd1);
      check("lat3_px0_r", 32'(if2.VGA_R), 32'h00);
      wait_for(WXy2, 6, 40, "lat3_x6");
      check("lat3_px3_rgb", 32'({if2.VGA_R, if2.VGA_G, if2.VGA_B}), 32'h0328A5);
      check("lat3_px3_blank_n", 32'(if2.VGA_BLANK_N), 32'd1);
      wait_for(WXy2, 642, 40, "lat3_x642");
      check("lat3_px639_r", 32'(if2.VGA_R), 32'h7F);
      check("lat3_px639_blank_n", 32'(if2.VGA_BLANK_N), 32'd1);
      wait_for(WXy2, 643, 40, "lat3_x643");
      check("lat3_px640_rgb", 32'({if2.VGA_R, if2.VGA_G, if2.VGA_B}), 32'd0);
      check("lat3_px640_blank_n", 32'(if2.VGA_BLANK_N), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel timing and output stage for the vga core: divides CLOCK_50 to a pixel-rate enable and runs the horizontal and vertical counters for 640x480@60.
- Issues the pixel coordinate (x, y) and active flag to the pixel-colour logic, then samples that logic's rgb_in back.
- Drives VGA_R/G/B, VGA_HS, VGA_VS and VGA_BLANK_N with sync and blank delayed to line up with the colour pipeline.
- Sits directly upstream of the top-level DESim painter, which consumes its RGB.

Parameters:
- CLK_DIV, 2, CLOCK_50 cycles per pixel (at least 1).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_POL, 0, sync active level (0 means active-low).
- PIPE_LAT, 1, pixel periods from coordinate issue to RGB output (at least 1).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- rgb_in  in  24  {R,G,B} for the pixel issued PIPE_LAT-1 pixels earlier.
- pix_en  out  1  one-CLOCK_50-cycle pulse per pixel period.
- x  out  10  current h_count.
- y  out  9  current v_count, low 9 bits.
- active  out  1  current pixel is in the visible area.
- line_start  out  1  pulse, equal to pix_en && h_count==0.
- frame_start  out  1  pulse, equal to pix_en && h_count==0 && v_count==0.
- VGA_R  out  8  red.
- VGA_G  out  8  green.
- VGA_B  out  8  blue.
- VGA_HS  out  1  horizontal sync.
- VGA_VS  out  1  vertical sync.
- VGA_BLANK_N  out  1  low while blanked.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset, applied on the CLOCK_50 edge while reset=1:
  - div_cnt=0, h_count=0, v_count=0.
  - Control pipeline filled with idle (sync inactive, blank).
  - VGA_R/G/B=0, VGA_BLANK_N=0.
  - VGA_HS and VGA_VS at the inactive level (~SYNC_POL).
  - pix_en, line_start and frame_start are 0 while reset=1.
- Reset mid-frame restarts at pixel (0,0) with no partial-line artefacts.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 exactly when div_cnt==CLK_DIV-1.
  - With CLK_DIV=2, the first pix_en is on the 2nd cycle after reset is released; after that every other cycle.
  - With CLK_DIV=1, pix_en is constantly 1 outside reset.
- Counters advance only on an edge where pix_en=1:
  - h_count increments and wraps H_TOTAL-1 to 0.
  - On that wrap, v_count increments and wraps V_TOTAL-1 to 0.
- Current-pixel decode, combinational from the registered counters:
  - active = (h_count<H_ACTIVE) && (v_count<V_ACTIVE).
  - hs_raw active for h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vs_raw active for v_count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
- Output pipeline, updated only on pix_en edges:
  - {hs_raw, vs_raw, active} goes through a PIPE_LAT-deep shift register.
  - VGA_HS and VGA_VS = the stage-PIPE_LAT value mapped to SYNC_POL.
  - VGA_BLANK_N = the stage-PIPE_LAT active bit.
  - The colour registers are loaded with rgb_in if the stage-(PIPE_LAT-1) active bit is set (the current active when PIPE_LAT=1), otherwise 0. Blanked pixels are therefore always black whatever rgb_in is.
  - Sync, blank and RGB therefore change on the same CLOCK_50 edge.
- rgb_in only matters on pix_en edges. The consumer must hold it stable on those edges; it may change freely in between.
- Latency: the pixel presented on x/y/active while pix_en=1 appears on the VGA_* outputs PIPE_LAT pixel periods later.
- y truncation: lines 512..524 are never active, so truncating v_count to 9 bits for y only aliases blank lines.

Test Plan:
- Reset, CLK_DIV=2:
  - Hold reset 5 cycles → all VGA_* idle (HS=VS=1, BLANK_N=0, RGB=0) and x=y=0.
  - Release → pix_en pulses on cycles 2,4,6… and frame_start on the first pix_en.
- Horizontal timing, defaults:
  - VGA_HS period = 1600 CLOCK_50 cycles, low width = 192 cycles.
  - VGA_HS falls 2 cycles after the pix_en edge at which x=656 was presented.
  - line_start period = 1600 cycles.
- Vertical timing:
  - frame_start period = 840000 cycles.
  - VGA_VS low for exactly 3200 cycles, starting at line 490.
  - VGA_BLANK_N high for exactly 640 pix_en periods per visible line and 0 on lines 480..524.
- Colour alignment:
  - Drive rgb_in={x[7:0], y[7:0], 8'hA5} combinationally.
  - Pixel (3,7) must appear as VGA_R=3, VGA_G=7, VGA_B=A5 in the pixel period where VGA_BLANK_N is high for it.
  - With rgb_in forced to FFFFFF, VGA_R/G/B must be 0 while h≥640.
- Reset mid-frame: assert reset at line 200, pixel 300 for 1 cycle → next frame_start occurs on the first pix_en after release and x/y restart at 0/0.
- Parameter sweep:
  - CLK_DIV=1, PIPE_LAT=3 → pix_en constantly high and line period 800 cycles.
  - The RGB-to-coordinate offset equals 3 pixels, still aligned with BLANK_N.
